// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register with load formatting and register-file write gating.
// Also keeps a free-running retired-instruction counter for bring-up.
module wb_writeback_stage #(
  parameter int COUNT_WIDTH = 32,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_stall,
  input  logic                   in_flush,
  input  logic                   in_valid,
  input  logic                   in_RegWrite,
  input  logic                   in_MemToReg,
  input  logic [1:0]             in_load_mode,
  input  logic [4:0]             in_write_register,
  input  logic [31:0]            in_alu_result,
  input  logic [31:0]            in_read_data,
  output logic [4:0]             write_register_out,
  output logic [31:0]            write_data_out,
  output logic                   RegWrite_out,
  output logic                   valid_out,
  output logic                   align_error_out,
  output logic [COUNT_WIDTH-1:0] retired_count_out
);

  typedef enum logic [1:0] {
    LM_WORD  = 2'b00,
    LM_HALF  = 2'b01,
    LM_BYTE  = 2'b10,
    LM_UBYTE = 2'b11
  } load_mode_e;

  logic                   valid_q;
  logic                   regwrite_q;
  logic                   memtoreg_q;
  load_mode_e             load_mode_q;
  logic [4:0]             wreg_q;
  logic [31:0]            alu_q;
  logic [31:0]            rdata_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   leave_stage;

  // Contents leave on any edge that is not a pure stall; a flush drops them after they count.
  assign leave_stage = valid_q & (~in_stall | in_flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      load_mode_q <= LM_WORD;
      wreg_q      <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
    end else if (in_flush || !in_stall) begin
      valid_q     <= in_valid & ~in_flush;
      regwrite_q  <= in_RegWrite;
      memtoreg_q  <= in_MemToReg;
      load_mode_q <= load_mode_e'(in_load_mode);
      wreg_q      <= in_write_register;
      alu_q       <= in_alu_result;
      rdata_q     <= in_read_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (leave_stage) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  logic [1:0]  off;
  logic [1:0]  byte_lane;
  logic        half_upper;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;
  logic        misaligned;

  assign off        = alu_q[1:0];
  // Lanes are counted from the LSB; big-endian offset 0 lives in the top lane.
  assign byte_lane  = BIG_ENDIAN ? ~off : off;
  assign half_upper = BIG_ENDIAN ? ~off[1] : off[1];
  assign byte_val   = rdata_q[{byte_lane, 3'b000} +: 8];
  assign half_val   = half_upper ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data  = rdata_q;
    misaligned = 1'b0;
    case (load_mode_q)
      LM_WORD: begin
        load_data  = rdata_q;
        misaligned = (off != 2'b00);
      end
      LM_HALF: begin
        load_data  = {{16{half_val[15]}}, half_val};
        misaligned = off[0];
      end
      LM_BYTE: begin
        load_data  = {{24{byte_val[7]}}, byte_val};
      end
      LM_UBYTE: begin
        load_data  = {24'd0, byte_val};
      end
      default: begin
        load_data  = rdata_q;
        misaligned = 1'b0;
      end
    endcase
  end

  assign align_error_out    = valid_q & memtoreg_q & misaligned;
  assign write_data_out     = memtoreg_q ? load_data : alu_q;
  assign write_register_out = wreg_q;
  assign RegWrite_out       = valid_q & regwrite_q & (wreg_q != 5'd0) & ~align_error_out;
  assign valid_out          = valid_q;
  assign retired_count_out  = count_q;

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Bench for wb_writeback_stage: directed vector table, stall/flush/wrap sequences,
// then random traffic against a reference model of the stage.
module tb_wb_writeback_stage;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_stall;
  logic          in_flush;
  logic          in_valid;
  logic          in_RegWrite;
  logic          in_MemToReg;
  logic [1:0]    in_load_mode;
  logic [4:0]    in_write_register;
  logic [31:0]   in_alu_result;
  logic [31:0]   in_read_data;
  logic [4:0]    write_register_out;
  logic [31:0]   write_data_out;
  logic          RegWrite_out;
  logic          valid_out;
  logic          align_error_out;
  logic [CW-1:0] retired_count_out;

  wb_writeback_stage #(.COUNT_WIDTH(CW), .BIG_ENDIAN(1'b1)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_stall           (in_stall),
    .in_flush           (in_flush),
    .in_valid           (in_valid),
    .in_RegWrite        (in_RegWrite),
    .in_MemToReg        (in_MemToReg),
    .in_load_mode       (in_load_mode),
    .in_write_register  (in_write_register),
    .in_alu_result      (in_alu_result),
    .in_read_data       (in_read_data),
    .write_register_out (write_register_out),
    .write_data_out     (write_data_out),
    .RegWrite_out       (RegWrite_out),
    .valid_out          (valid_out),
    .align_error_out    (align_error_out),
    .retired_count_out  (retired_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction currently sitting in the stage.
  bit          m_valid, m_rw, m_m2r;
  bit [1:0]    m_mode;
  bit [4:0]    m_wreg;
  bit [31:0]   m_alu, m_rd;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Big-endian memory view: offset k is byte (3-k) counting from the LSB.
  function automatic bit [7:0] mem_byte(input bit [31:0] word, input int k);
    return 8'((word >> (8 * (3 - k))) & 32'hFF);
  endfunction

  task automatic model_outputs(output bit [31:0] data, output bit we, output bit err);
    int        off;
    bit [31:0] ld;
    bit        mis;
    bit [15:0] h;
    bit [7:0]  b;
    off = int'(m_alu % 4);
    ld  = m_rd;
    mis = 1'b0;
    case (m_mode)
      2'd0: begin ld = m_rd; mis = (off != 0); end
      2'd1: begin
        h   = {mem_byte(m_rd, (off / 2) * 2), mem_byte(m_rd, (off / 2) * 2 + 1)};
        ld  = h[15] ? (32'hFFFF0000 | 32'(h)) : 32'(h);
        mis = (off % 2) == 1;
      end
      2'd2: begin b = mem_byte(m_rd, off); ld = b[7] ? (32'hFFFFFF00 | 32'(b)) : 32'(b); end
      default: begin b = mem_byte(m_rd, off); ld = 32'(b); end
    endcase
    err  = m_valid && m_m2r && mis;
    data = m_m2r ? ld : m_alu;
    we   = m_valid && m_rw && (m_wreg != 0) && !err;
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_mode = 0;
    m_wreg = 0; m_alu = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (m_valid && (!in_stall || in_flush)) m_cnt = (m_cnt + 1) % (1 << CW);
    if (in_flush || !in_stall) begin
      m_valid = in_valid && !in_flush;
      m_rw    = in_RegWrite;
      m_m2r   = in_MemToReg;
      m_mode  = in_load_mode;
      m_wreg  = in_write_register;
      m_alu   = in_alu_result;
      m_rd    = in_read_data;
    end
  endtask

  task automatic compare_all(input string tag);
    bit [31:0] d;
    bit        we, err;
    model_outputs(d, we, err);
    check({tag, ".wreg"},  32'(write_register_out), 32'(m_wreg));
    check({tag, ".data"},  write_data_out, d);
    check({tag, ".we"},    32'(RegWrite_out), 32'(we));
    check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    check({tag, ".err"},   32'(align_error_out), 32'(err));
    check({tag, ".count"}, 32'(retired_count_out), 32'(m_cnt));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input bit [1:0] mode,
                       input bit [4:0] wreg, input bit [31:0] alu, input bit [31:0] rd);
    in_valid = v; in_RegWrite = rw; in_MemToReg = m2r; in_load_mode = mode;
    in_write_register = wreg; in_alu_result = alu; in_read_data = rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit [1:0]  mode;
    bit        m2r;
    bit        rw;
    bit [4:0]  wreg;
    bit [31:0] alu;
    bit [31:0] rd;
    bit [31:0] exp_data;
    bit        exp_we;
    bit        exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit [31:0] held;
    int        cnt0;
    string     tag;

    vecs[0]  = '{2'd0, 1'b0, 1'b1, 5'd9,  32'h0000_1234, 32'h80F1_7F22, 32'h0000_1234, 1'b1, 1'b0};
    vecs[1]  = '{2'd2, 1'b1, 1'b1, 5'd3,  32'h0000_1001, 32'h80F1_7F22, 32'hFFFF_FFF1, 1'b1, 1'b0};
    vecs[2]  = '{2'd3, 1'b1, 1'b1, 5'd3,  32'h0000_1001, 32'h80F1_7F22, 32'h0000_00F1, 1'b1, 1'b0};
    vecs[3]  = '{2'd1, 1'b1, 1'b1, 5'd3,  32'h0000_1002, 32'h80F1_7F22, 32'h0000_7F22, 1'b1, 1'b0};
    vecs[4]  = '{2'd0, 1'b1, 1'b1, 5'd3,  32'h0000_1000, 32'h80F1_7F22, 32'h80F1_7F22, 1'b1, 1'b0};
    vecs[5]  = '{2'd1, 1'b1, 1'b1, 5'd4,  32'h0000_1001, 32'h80F1_7F22, 32'hFFFF_80F1, 1'b0, 1'b1};
    vecs[6]  = '{2'd1, 1'b1, 1'b1, 5'd0,  32'h0000_1000, 32'h80F1_7F22, 32'hFFFF_80F1, 1'b0, 1'b0};
    vecs[7]  = '{2'd2, 1'b1, 1'b1, 5'd7,  32'h0000_1000, 32'h80F1_7F22, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[8]  = '{2'd3, 1'b1, 1'b1, 5'd7,  32'h0000_1003, 32'h80F1_7F22, 32'h0000_0022, 1'b1, 1'b0};
    vecs[9]  = '{2'd0, 1'b1, 1'b1, 5'd8,  32'h0000_1002, 32'h80F1_7F22, 32'h80F1_7F22, 1'b0, 1'b1};
    vecs[10] = '{2'd0, 1'b0, 1'b1, 5'd8,  32'h0000_1003, 32'h80F1_7F22, 32'h0000_1003, 1'b1, 1'b0};
    vecs[11] = '{2'd3, 1'b1, 1'b0, 5'd8,  32'h0000_1002, 32'h80F1_7F22, 32'h0000_007F, 1'b0, 1'b0};

    rst_n = 1'b0; in_stall = 0; in_flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    compare_all("por");
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 3; i++) tick("idle");

    // Directed vectors, back to back.
    for (int i = 0; i < 12; i++) begin
      drive(1, vecs[i].rw, vecs[i].m2r, vecs[i].mode, vecs[i].wreg, vecs[i].alu, vecs[i].rd);
      tag = $sformatf("vec%0d", i);
      tick(tag);
      check({tag, ".tbl_data"}, write_data_out, vecs[i].exp_data);
      check({tag, ".tbl_we"},   32'(RegWrite_out), 32'(vecs[i].exp_we));
      check({tag, ".tbl_err"},  32'(align_error_out), 32'(vecs[i].exp_err));
      check({tag, ".tbl_cnt"},  32'(retired_count_out), 32'(i % (1 << CW)));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("drain");
    check("drain.cnt", 32'(retired_count_out), 32'd12);

    // Asynchronous reset mid-cycle with a valid instruction in the stage.
    drive(1, 1, 0, 0, 5'd9, 32'h0000_1234, 32'h0);
    tick("pre_async");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async.we",    32'(RegWrite_out), 32'd0);
    check("async.valid", 32'(valid_out), 32'd0);
    check("async.data",  write_data_out, 32'd0);
    check("async.cnt",   32'(retired_count_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("post_async");

    // Stall holds a valid write; release retires it once; flush beats stall.
    drive(1, 1, 0, 0, 5'd5, 32'hCAFE_0005, 32'h0);
    tick("stall_load");
    held = write_data_out;
    cnt0 = int'(retired_count_out);
    in_stall = 1;
    drive(1, 1, 1, 2'd1, 5'd11, 32'h1111_2223, 32'h5555_AAAA);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall.we_held",   32'(RegWrite_out), 32'd1);
      check("stall.data_held", write_data_out, held);
      check("stall.cnt_held",  32'(retired_count_out), 32'(cnt0));
    end
    in_stall = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("release");
    check("release.cnt", 32'(retired_count_out), 32'((cnt0 + 1) % (1 << CW)));
    drive(1, 1, 0, 0, 5'd6, 32'h0000_0066, 32'h0);
    tick("pre_flush");
    cnt0 = int'(retired_count_out);
    in_stall = 1; in_flush = 1;
    tick("flush_stall");
    check("flush.valid", 32'(valid_out), 32'd0);
    check("flush.cnt",   32'(retired_count_out), 32'((cnt0 + 1) % (1 << CW)));
    in_stall = 0; in_flush = 0;

    // Counter wrap: 17 back-to-back instructions then one empty edge.
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      if (i <= 17) drive(1, 1, 0, 0, 5'(i), 32'(i), 32'h0);
      else         drive(0, 0, 0, 0, 0, 0, 0);
      tick("wrap");
      if (i == 16) check("wrap.15", 32'(retired_count_out), 32'd15);
      if (i == 17) check("wrap.0",  32'(retired_count_out), 32'd0);
      if (i == 18) check("wrap.1",  32'(retired_count_out), 32'd1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_stall = ($urandom_range(0, 3) == 0);
      in_flush = ($urandom_range(0, 7) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
            5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, $urandom);
      tick("rand");
    end
    in_stall = 0; in_flush = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_writeback_stage.md
Name: wb_writeback_stage

Overview:
- MEM/WB pipeline register plus writeback formatting.
- Produces the register-file write port (`write_register`, `write_data`, `RegWrite`) consumed by the decode stage.
- Captures memory-stage results, formats load data per `load_mode`, selects ALU or load data, and gates the write.
- Keeps a retired-instruction counter for bring-up and performance checks.

Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter; wraps modulo 2^COUNT_WIDTH.
- BIG_ENDIAN, 1, 1 = byte offset 0 is bits [31:24] (MIPS big-endian); 0 = byte offset 0 is bits [7:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_stall  input  1  hold stage register contents
- in_flush  input  1  invalidate the incoming instruction
- in_valid  input  1  memory stage presents a real instruction
- in_RegWrite  input  1  instruction writes a register
- in_MemToReg  input  1  1 = load data, 0 = ALU result
- in_load_mode  input  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- in_write_register  input  5  destination register
- in_alu_result  input  32  ALU result / effective address
- in_read_data  input  32  raw 32-bit memory word (aligned)
- write_register_out  output  5  destination to register file
- write_data_out  output  32  formatted writeback data
- RegWrite_out  output  1  register-file write enable
- valid_out  output  1  stage holds a valid instruction
- align_error_out  output  1  misaligned load present in stage
- retired_count_out  output  COUNT_WIDTH  instructions retired since reset

Behaviour:
- Reset (`rst_n` low, asynchronous): all stage registers and the counter clear to 0 immediately. All outputs are then 0, including `RegWrite_out`.
- Reset release takes effect at the next rising edge.
- Stage register update, priority on each rising edge:
  - `in_flush`=1: `valid_q`←0; other fields are don't-care but are loaded anyway. Flush overrides stall.
  - Else `in_stall`=1: all fields hold.
  - Else: all fields load from the `in_*` ports; `valid_q`←`in_valid`.
- Latency: one cycle from input to outputs. Outputs are combinational from registered fields only; no input-to-output combinational path.
- Load formatting uses registered `alu_q[1:0]` as byte offset `off`:
  - 00 word: data unchanged. Misaligned if `off`≠0.
  - 01 half: halfword selected by `off[1]` (BIG_ENDIAN=1: `off[1]`=0 → [31:16]), sign-extended. Misaligned if `off[0]`=1.
  - 10 byte: byte selected by `off`, sign-extended from bit 7.
  - 11 byte: byte selected by `off`, zero-extended.
- Data selection: `write_data_out` = `memtoreg_q` ? formatted load : `alu_q`.
- `align_error_out` = `valid_q` & `memtoreg_q` & misaligned.
- `RegWrite_out` = `valid_q` & `regwrite_q` & (`wreg_q`≠0) & !`align_error_out`. Register $0 is never written.
- `write_register_out` = `wreg_q`, always driven, even when the write is disabled.
- Stall while valid: `RegWrite_out` stays asserted with identical data every cycle (idempotent rewrite).
- Retired counter: increments on a rising edge where `valid_q`=1 and `in_stall`=0, or where `valid_q`=1 and `in_flush`=1.
  - The contents leave the stage on such an edge, so they count exactly once.
  - Misaligned loads and $0 writes still count as retired.
  - Wraps from all-ones to 0.
- Reset mid-stall or mid-flush: reset wins; the stage is empty with count 0.

Test Plan:
- Reset then idle with `in_valid`=0 → `RegWrite_out`=0, `valid_out`=0, `retired_count_out`=0; assert `rst_n` low mid-cycle → outputs clear without a clock edge.
- ALU op, `in_RegWrite`=1, reg 9, `alu`=0x0000_1234, `MemToReg`=0 → next cycle `write_register_out`=9, `write_data_out`=0x0000_1234, `RegWrite_out`=1; count=1 after the following edge.
- Loads from `read_data`=0x80F1_7F22, BIG_ENDIAN=1, `MemToReg`=1:
  - mode 10, `off`=1 → 0xFFFF_FFF1
  - mode 11, `off`=1 → 0x0000_00F1
  - mode 01, `off`=2 → 0x0000_7F22
  - mode 00, `off`=0 → 0x80F1_7F22
- Misaligned: mode 01 with `off`=1 → `align_error_out`=1, `RegWrite_out`=0, count still increments; same instruction with reg 0 and `off`=0 → `RegWrite_out`=0.
- Stall then flush:
  - Valid write to reg 5 held with `in_stall`=1 for 3 cycles → `RegWrite_out`=1 throughout, data stable, count unchanged.
  - Release → count +1.
  - `in_flush` and `in_stall` both high → `valid_out`=0 next cycle.
- Counter wrap with COUNT_WIDTH=4: 17 back-to-back valid instructions → count sequence reaches 15, then 0, then 1.
